// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with fixed-priority writes, optional
//            write-to-read bypass, hardwired zero register and pending scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WR-1:0]          RegWrite,
    input  logic [NUM_WR*ADDR_W-1:0]   write_reg,
    input  logic [NUM_WR*DATA_W-1:0]   write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    input  logic                       pend_set,
    input  logic [ADDR_W-1:0]          pend_reg,
    output logic [NUM_RD-1:0]          read_pend
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;
    logic [DEPTH-1:0]             pend_q;
    logic [DEPTH-1:0]             pend_d;

    logic [NUM_WR-1:0]            w_we;
    logic                         w_pset;

    // Effective enables: writes and pend_set aimed at a hardwired r0 are dropped.
    generate
        for (genvar k = 0; k < NUM_WR; k++) begin : g_we
            assign w_we[k] = RegWrite[k] &&
                             !((ZERO_REG != 0) && (write_reg[k*ADDR_W +: ADDR_W] == '0));
        end
    endgenerate

    assign w_pset = pend_set && !((ZERO_REG != 0) && (pend_reg == '0));

    // Higher-index write ports are applied last so they win on conflicts;
    // pend_set is applied after the writes so a new producer supersedes.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (w_we[k]) begin
                mem_d[write_reg[k*ADDR_W +: ADDR_W]]  = write_data[k*DATA_W +: DATA_W];
                pend_d[write_reg[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (w_pset) begin
            pend_d[pend_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    generate
        for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_data;
            logic              w_pend;

            assign w_ra = read_reg[j*ADDR_W +: ADDR_W];

            always_comb begin
                w_data = mem_q[w_ra];
                w_pend = pend_q[w_ra];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (w_we[k] && (write_reg[k*ADDR_W +: ADDR_W] == w_ra)) begin
                            w_data = write_data[k*DATA_W +: DATA_W];
                            w_pend = 1'b0;
                        end
                    end
                end
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_data = '0;
                    w_pend = 1'b0;
                end
                if (reset) begin
                    w_data = '0;
                    w_pend = 1'b0;
                end
            end

            assign read_data[j*DATA_W +: DATA_W] = w_data;
            assign read_pend[j]                  = w_pend;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed table plus randomized model check of regfile_mp, with
//            bypassing and non-bypassing instances sharing one stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NW-1:0]     RegWrite;
    logic [NW*AW-1:0]  write_reg;
    logic [NW*DW-1:0]  write_data;
    logic [NR*AW-1:0]  read_reg;
    logic              pend_set;
    logic [AW-1:0]     pend_reg;
    logic [NR*DW-1:0]  rd_b, rd_n;
    logic [NR-1:0]     rp_b, rp_n;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)) dut_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_reg(write_reg),
        .write_data(write_data), .read_reg(read_reg), .read_data(rd_b),
        .pend_set(pend_set), .pend_reg(pend_reg), .read_pend(rp_b));

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_reg(write_reg),
        .write_data(write_data), .read_reg(read_reg), .read_data(rd_n),
        .pend_set(pend_set), .pend_reg(pend_reg), .read_pend(rp_n));

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_mem [32];
    bit            ref_pend [32];

    typedef struct {
        bit          rst;
        bit [1:0]    we;
        int          wa0;
        logic [31:0] wd0;
        int          wa1;
        logic [31:0] wd1;
        int          ra0;
        int          ra1;
        bit          ps;
        int          pr;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        bit          e_p0;
        bit          e_p1;
        logic [31:0] n_d0;
        bit          n_p0;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_data(bit byp, int j);
        int a = int'(read_reg[j*AW +: AW]);
        if (reset || a == 0) return 32'h0;
        if (byp) begin
            if (RegWrite[1] && int'(write_reg[AW +: AW]) == a) return write_data[DW +: DW];
            if (RegWrite[0] && int'(write_reg[0 +: AW]) == a) return write_data[0 +: DW];
        end
        return ref_mem[a];
    endfunction

    function automatic bit mdl_pend(bit byp, int j);
        int a = int'(read_reg[j*AW +: AW]);
        if (reset || a == 0) return 1'b0;
        if (byp) begin
            for (int k = 0; k < NW; k++)
                if (RegWrite[k] && int'(write_reg[k*AW +: AW]) == a) return 1'b0;
        end
        return ref_pend[a];
    endfunction

    task automatic drive(bit rst, bit [1:0] we, int wa0, logic [31:0] wd0, int wa1,
                         logic [31:0] wd1, int ra0, int ra1, bit ps, int pr);
        reset      = rst;
        RegWrite   = we;
        write_reg  = {AW'(wa1), AW'(wa0)};
        write_data = {wd1, wd0};
        read_reg   = {AW'(ra1), AW'(ra0)};
        pend_set   = ps;
        pend_reg   = AW'(pr);
    endtask

    // Compares both instances against the model, then advances one edge and
    // commits the same inputs into the model.
    task automatic model_cycle();
        int a;
        for (int j = 0; j < NR; j++) begin
            chk($sformatf("byp_data%0d", j), rd_b[j*DW +: DW], mdl_data(1'b1, j));
            chk($sformatf("byp_pend%0d", j), 32'(rp_b[j]), 32'(mdl_pend(1'b1, j)));
            chk($sformatf("nb_data%0d", j), rd_n[j*DW +: DW], mdl_data(1'b0, j));
            chk($sformatf("nb_pend%0d", j), 32'(rp_n[j]), 32'(mdl_pend(1'b0, j)));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                ref_mem[i]  = '0;
                ref_pend[i] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                a = int'(write_reg[k*AW +: AW]);
                if (RegWrite[k] && a != 0) begin
                    ref_mem[a]  = write_data[k*DW +: DW];
                    ref_pend[a] = 1'b0;
                end
            end
            if (pend_set && pend_reg != 0) ref_pend[int'(pend_reg)] = 1'b1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]  = '0;
            ref_pend[i] = 1'b0;
        end
        drive(1'b1, 2'b00, 0, 0, 0, 0, 5, 6, 1'b0, 0);
        #4; model_cycle();
        #3; model_cycle();

        //           rst we    wa0 wd0           wa1 wd1          ra0 ra1 ps pr  e_d0          e_d1          p0 p1 n_d0          n_p0
        vecs.push_back('{0, 2'b01, 5, 32'hDEADBEEF, 0, 0,            5, 6, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        0});
        vecs.push_back('{1, 2'b01, 6, 32'h11111111, 0, 0,            5, 6, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            5, 6, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0});
        vecs.push_back('{0, 2'b01, 18, 32'h000FF404, 0, 0,           18, 0, 0, 0, 32'h000FF404, 32'h0,       0, 0, 32'h0,        0});
        vecs.push_back('{0, 2'b01, 0, 32'h1234,     0, 0,            18, 0, 0, 0, 32'h000FF404, 32'h0,       0, 0, 32'h000FF404, 0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            0, 18, 0, 0, 32'h0,        32'h000FF404, 0, 0, 32'h0,       0});
        vecs.push_back('{0, 2'b01, 12, 32'hA5A5A5A5, 0, 0,           12, 12, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'h0,     0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            12, 12, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0});
        vecs.push_back('{0, 2'b11, 7, 32'h1,        7, 32'h2,        7, 7, 0, 0, 32'h2,        32'h2,        0, 0, 32'h0,        0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            7, 7, 0, 0, 32'h2,        32'h2,        0, 0, 32'h2,        0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            9, 9, 1, 9, 32'h0,        32'h0,        0, 0, 32'h0,        0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            9, 9, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0,        1});
        vecs.push_back('{0, 2'b01, 9, 32'h99,       0, 0,            9, 9, 0, 0, 32'h99,       32'h99,       0, 0, 32'h0,        1});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            9, 9, 0, 0, 32'h99,       32'h99,       0, 0, 32'h99,       0});
        vecs.push_back('{0, 2'b01, 9, 32'h77,       0, 0,            9, 9, 1, 9, 32'h77,       32'h77,       0, 0, 32'h99,       0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            9, 9, 0, 0, 32'h77,       32'h77,       1, 1, 32'h77,       1});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            0, 9, 1, 0, 32'h0,        32'h77,       0, 1, 32'h0,        0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            0, 9, 0, 0, 32'h0,        32'h77,       0, 1, 32'h0,        0});
        vecs.push_back('{0, 2'b01, 3, 32'hCAFE,     0, 0,            3, 4, 1, 3, 32'hCAFE,     32'h0,        0, 0, 32'h0,        0});
        vecs.push_back('{0, 2'b10, 0, 0,            4, 32'hBEEF,     3, 4, 1, 4, 32'hCAFE,     32'hBEEF,     1, 0, 32'hCAFE,     1});
        vecs.push_back('{1, 2'b00, 0, 0,            0, 0,            3, 4, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0});
        vecs.push_back('{0, 2'b00, 0, 0,            0, 0,            3, 4, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0});

        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].wa0, vecs[v].wd0, vecs[v].wa1,
                  vecs[v].wd1, vecs[v].ra0, vecs[v].ra1, vecs[v].ps, vecs[v].pr);
            #4;
            chk($sformatf("vec%0d_d0", v), rd_b[0 +: DW], vecs[v].e_d0);
            chk($sformatf("vec%0d_d1", v), rd_b[DW +: DW], vecs[v].e_d1);
            chk($sformatf("vec%0d_p0", v), 32'(rp_b[0]), 32'(vecs[v].e_p0));
            chk($sformatf("vec%0d_p1", v), 32'(rp_b[1]), 32'(vecs[v].e_p1));
            chk($sformatf("vec%0d_nb_d0", v), rd_n[0 +: DW], vecs[v].n_d0);
            chk($sformatf("vec%0d_nb_p0", v), 32'(rp_n[0]), 32'(vecs[v].n_p0));
            model_cycle();
        end

        // Small address range keeps collisions between ports frequent.
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 39) == 0, 2'($urandom),
                  int'($urandom_range(0, 7)), $urandom,
                  int'($urandom_range(0, 7)), $urandom,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
            #4;
            model_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
